// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : D-stage hazard unit: shadow writer pipeline with Tnew count-down,
//            stall / forwarding-select generation and a stall-cycle counter.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
    parameter int STAGES = 3,
    parameter int AW     = 5,
    parameter int TW     = 2,
    parameter int SW     = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          freeze,
    input  logic          flush,
    input  logic [AW-1:0] d_a1,
    input  logic [TW-1:0] d_tuse1,
    input  logic [AW-1:0] d_a2,
    input  logic [TW-1:0] d_tuse2,
    input  logic [AW-1:0] d_a3,
    input  logic [TW-1:0] d_tnew,
    output logic          stall,
    output logic [SW-1:0] fwd_sel1,
    output logic [SW-1:0] fwd_sel2,
    output logic [31:0]   stall_cnt
);

    logic [AW-1:0] a3_q   [STAGES];
    logic [TW-1:0] tnew_q [STAGES];
    logic [AW-1:0] a3_d   [STAGES];
    logic [TW-1:0] tnew_d [STAGES];
    logic [31:0]   stall_cnt_q;
    logic [31:0]   stall_cnt_d;

    logic [1:0][AW-1:0] w_src_a;
    logic [1:0][TW-1:0] w_src_tuse;
    logic [1:0]         w_src_stall;
    logic [1:0][SW-1:0] w_src_sel;

    assign w_src_a    = {d_a2, d_a1};
    assign w_src_tuse = {d_tuse2, d_tuse1};

    // Scan oldest to youngest so the youngest matching writer wins.
    for (genvar s = 0; s < 2; s++) begin : g_src
        logic          hit;
        logic [TW-1:0] hit_tnew;
        logic [SW-1:0] hit_sel;

        always_comb begin
            hit      = 1'b0;
            hit_tnew = '0;
            hit_sel  = '0;
            for (int i = STAGES - 1; i >= 0; i--) begin
                if (w_src_a[s] != '0 && a3_q[i] == w_src_a[s]) begin
                    hit      = 1'b1;
                    hit_tnew = tnew_q[i];
                    hit_sel  = SW'(i + 1);
                end
            end
        end

        assign w_src_stall[s] = hit && (hit_tnew > w_src_tuse[s]);
        assign w_src_sel[s]   = (hit && hit_tnew == '0) ? hit_sel : '0;
    end

    assign stall     = |w_src_stall;
    assign fwd_sel1  = w_src_sel[0];
    assign fwd_sel2  = w_src_sel[1];
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            a3_d[i]   = a3_q[i];
            tnew_d[i] = tnew_q[i];
        end
        stall_cnt_d = stall_cnt_q;
        if (!freeze) begin
            for (int i = 1; i < STAGES; i++) begin
                a3_d[i]   = a3_q[i-1];
                tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
            end
            if (stall || flush) begin
                a3_d[0]   = '0;
                tnew_d[0] = '0;
            end else begin
                a3_d[0]   = d_a3;
                tnew_d[0] = (d_a3 != '0) ? d_tnew : '0;
            end
            if (stall) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                a3_q[i]   <= '0;
                tnew_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                a3_q[i]   <= a3_d[i];
                tnew_q[i] <= tnew_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed self-checking bench for hazard_scoreboard (STAGES=3).
// Revision : 1.0
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        freeze;
    logic        flush;
    logic [4:0]  d_a1;
    logic [1:0]  d_tuse1;
    logic [4:0]  d_a2;
    logic [1:0]  d_tuse2;
    logic [4:0]  d_a3;
    logic [1:0]  d_tnew;
    logic        stall;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
    logic [31:0] stall_cnt;

    int tests;
    int fails;

    hazard_scoreboard #(
        .STAGES(3),
        .AW    (5),
        .TW    (2),
        .SW    (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .freeze   (freeze),
        .flush    (flush),
        .d_a1     (d_a1),
        .d_tuse1  (d_tuse1),
        .d_a2     (d_a2),
        .d_tuse2  (d_tuse2),
        .d_a3     (d_a3),
        .d_tnew   (d_tnew),
        .stall    (stall),
        .fwd_sel1 (fwd_sel1),
        .fwd_sel2 (fwd_sel2),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle inputs/outputs away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        freeze  = 1'b0;
        flush   = 1'b0;
        d_a1    = '0;
        d_tuse1 = '0;
        d_a2    = '0;
        d_tuse2 = '0;
        d_a3    = '0;
        d_tnew  = '0;
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_sel1", 32'(fwd_sel1), 32'd0);
        check("rst_sel2", 32'(fwd_sel2), 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // lw $8 (tnew=2) then addu using $8 at tuse=1
        d_a3 = 5'd8; d_tnew = 2'd2;
        tick();
        d_a3 = '0; d_tnew = '0; d_a1 = 5'd8; d_tuse1 = 2'd1;
        #1;
        check("lw_stall", 32'(stall), 32'd1);
        check("lw_sel_during_stall", 32'(fwd_sel1), 32'd0);
        tick();
        check("lw_cnt", stall_cnt, 32'd1);
        check("lw_tnew_eq_tuse_nostall", 32'(stall), 32'd0);
        check("lw_tnew_eq_tuse_sel", 32'(fwd_sel1), 32'd0);
        tick();
        check("lw_fwd_e2", 32'(fwd_sel1), 32'd3);
        check("lw_nostall", 32'(stall), 32'd0);
        check("lw_cnt_hold", stall_cnt, 32'd1);

        // ori $9 (tnew=1) then beq $9 at tuse=0
        d_a1 = '0; d_tuse1 = '0; d_a3 = 5'd9; d_tnew = 2'd1;
        tick();
        d_a3 = '0; d_tnew = '0; d_a1 = 5'd9;
        #1;
        check("ori_stall", 32'(stall), 32'd1);
        tick();
        check("ori_cnt", stall_cnt, 32'd2);
        check("ori_fwd_e1", 32'(fwd_sel1), 32'd2);
        check("ori_nostall", 32'(stall), 32'd0);

        // two writers of $5: entry 2 (older) and entry 0 (youngest, tnew=0)
        d_a1 = '0; d_a3 = 5'd5; d_tnew = 2'd1;
        tick();
        d_a3 = '0; d_tnew = '0;
        tick();
        d_a3 = 5'd5; d_tnew = 2'd0;
        tick();
        d_a3 = '0; d_a1 = 5'd5; d_tuse1 = 2'd0; d_a2 = 5'd5; d_tuse2 = 2'd2;
        #1;
        check("dup_sel1_youngest", 32'(fwd_sel1), 32'd1);
        check("dup_sel2_youngest", 32'(fwd_sel2), 32'd1);
        check("dup_nostall", 32'(stall), 32'd0);

        // writer of $0 enters as bubble; $0 source never matches
        d_a1 = '0; d_a2 = '0; d_tuse2 = '0; d_a3 = '0; d_tnew = 2'd3;
        tick();
        d_tnew = '0; d_a2 = 5'd5;
        #1;
        check("r0_stall", 32'(stall), 32'd0);
        check("r0_sel1", 32'(fwd_sel1), 32'd0);
        check("r0_shift_sel2", 32'(fwd_sel2), 32'd2);
        check("r0_cnt", stall_cnt, 32'd2);

        // freeze during a hazard, then flush
        d_a2 = '0; d_a3 = 5'd7; d_tnew = 2'd2;
        tick();
        d_a3 = '0; d_tnew = '0; d_a1 = 5'd7; d_a2 = 5'd5; d_tuse2 = 2'd3;
        #1;
        check("frz_pre_stall", 32'(stall), 32'd1);
        check("frz_pre_sel2", 32'(fwd_sel2), 32'd3);
        freeze = 1'b1;
        tick();
        check("frz_stall_held", 32'(stall), 32'd1);
        check("frz_cnt_held", stall_cnt, 32'd2);
        check("frz_entries_held", 32'(fwd_sel2), 32'd3);
        freeze = 1'b0; flush = 1'b1; d_a3 = 5'd6;
        tick();
        flush = 1'b0; d_a3 = '0; d_a2 = '0; d_tuse2 = '0;
        #1;
        check("flush_cnt", stall_cnt, 32'd3);
        check("flush_old_stall", 32'(stall), 32'd1);
        d_a1 = 5'd6;
        #1;
        check("flush_nomatch_stall", 32'(stall), 32'd0);
        check("flush_nomatch_sel", 32'(fwd_sel1), 32'd0);

        // flush alone with no stall still bubbles entry 0
        d_a1 = '0; flush = 1'b1; d_a3 = 5'd6; d_tnew = 2'd0;
        tick();
        flush = 1'b0; d_a3 = '0; d_a1 = 5'd6;
        #1;
        check("flush_only_sel", 32'(fwd_sel1), 32'd0);
        check("flush_only_cnt", stall_cnt, 32'd3);
        d_a1 = 5'd7;
        #1;
        check("flush_only_old_fwd", 32'(fwd_sel1), 32'd3);

        // async reset mid-stall
        d_a1 = '0; d_a3 = 5'd3; d_tnew = 2'd3;
        tick();
        d_a3 = '0; d_tnew = '0; d_a1 = 5'd3; d_tuse1 = 2'd0;
        #1;
        check("mid_pre_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_sel1", 32'(fwd_sel1), 32'd0);
        check("mid_rst_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_nomatch", 32'(stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
